// File: rtl/udp_header_tx_pkg.sv
// rtl/udp_header_tx_pkg.sv - shared constants and state type for the UDP header transmitter
package udp_header_tx_pkg;

    localparam int DST_MAC_OFF   = 0;
    localparam int DST_IP_OFF    = 6;
    localparam int DST_PORT_OFF  = 10;
    localparam int HDR_FETCH_LEN = 12;
    localparam int HDR_LEN       = 42;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
    localparam logic [15:0] MAX_PAYLOAD    = 16'd65507;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CSUM,
        SEND
    } state_e;

endpackage

// File: rtl/udp_header_tx_ip_csum16.sv
// rtl/udp_header_tx_ip_csum16.sv - ones'-complement 16-bit word accumulator with fold/invert result
module ip_csum16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] add_word,
    input  logic        fold_en,
    output logic [15:0] csum
);

    logic [19:0] acc_q, acc_d;
    logic [15:0] csum_q, csum_d;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Twenty bits hold up to sixteen full words, so two folds always settle the carries.
    always_comb begin
        fold1  = {1'b0, acc_q[15:0]} + {13'b0, acc_q[19:16]};
        fold2  = fold1[15:0] + {15'b0, fold1[16]};
        acc_d  = acc_q;
        csum_d = csum_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + {4'b0, add_word};
        end
        if (fold_en) begin
            csum_d = ~fold2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;

endmodule

// File: rtl/udp_header_tx.sv
// rtl/udp_header_tx.sv - fetches destination fields from header RAM and streams a 42-byte Eth/IPv4/UDP header
// Optional macro UDP_HEADER_IP_ID_COUNTER_EN: IPv4 ID increments after every completed header.
module udp_header_tx
    import udp_header_tx_pkg::*;
#(
    parameter int          aw       = 5,
    parameter logic [47:0] SRC_MAC  = 48'h00105AD15500,
    parameter logic [31:0] SRC_IP   = 32'hC0A80102,
    parameter logic [15:0] SRC_PORT = 16'h80F0,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   payload_len,
    output logic          busy,
    output logic          err,
    output logic [aw-1:0] hdr_addr,
    input  logic [7:0]    hdr_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [aw-1:0]   hdr_addr_q, hdr_addr_d;
    logic [15:0]     len_q, len_d;
    logic            err_q, err_d;
    logic [7:0]      dst_q [HDR_FETCH_LEN];
    logic [7:0]      dst_d [HDR_FETCH_LEN];

    logic [15:0]     ip_id;
    logic [15:0]     total_len, udp_len;
    logic            csum_clr, csum_add, csum_fold;
    logic [15:0]     csum_word, csum;
    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [7:0]      hdr_bytes [HDR_LEN];

    assign total_len = len_q + 16'd28;
    assign udp_len   = len_q + 16'd8;

`ifdef UDP_HEADER_IP_ID_COUNTER_EN
    logic [15:0] ip_id_q, ip_id_d;
    logic        last_accept;

    assign last_accept = (state_q == SEND) && out_ready && (idx_q == 6'(HDR_LEN - 1));

    always_comb begin
        ip_id_d = ip_id_q;
        if (last_accept) begin
            ip_id_d = ip_id_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_id_q <= '0;
        end else begin
            ip_id_q <= ip_id_d;
        end
    end

    assign ip_id = ip_id_q;
`else
    assign ip_id = 16'h0000;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        hdr_addr_d = hdr_addr_q;
        len_d      = len_q;
        err_d      = 1'b0;
        dst_d      = dst_q;
        csum_clr   = 1'b0;
        csum_add   = 1'b0;
        csum_word  = '0;
        csum_fold  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (payload_len > MAX_PAYLOAD) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = payload_len;
                        cnt_d      = '0;
                        hdr_addr_d = '0;
                        csum_clr   = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                // RAM data lags the address by one cycle, so cycle k captures byte k-1.
                if (cnt_q != 4'd0) begin
                    dst_d[cnt_q - 4'd1] = hdr_data;
                end
                // Constant IP words are summed early; dest IP words once their bytes have landed.
                csum_add = 1'b1;
                case (cnt_q)
                    4'd0:    csum_word = IP_VER_IHL_TOS;
                    4'd1:    csum_word = total_len;
                    4'd2:    csum_word = ip_id;
                    4'd3:    csum_word = {TTL, IP_PROTO_UDP};
                    4'd4:    csum_word = SRC_IP[31:16];
                    4'd5:    csum_word = SRC_IP[15:0];
                    4'd9:    csum_word = {dst_q[DST_IP_OFF], dst_q[DST_IP_OFF+1]};
                    default: csum_add  = 1'b0;
                endcase
                hdr_addr_d = (cnt_q < 4'(HDR_FETCH_LEN - 1)) ? aw'(cnt_q + 4'd1) : '0;
                if (cnt_q == 4'(HDR_FETCH_LEN)) begin
                    cnt_d   = '0;
                    state_d = CSUM;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CSUM: begin
                if (cnt_q == 4'd0) begin
                    csum_add  = 1'b1;
                    csum_word = {dst_q[DST_IP_OFF+2], dst_q[DST_IP_OFF+3]};
                    cnt_d     = 4'd1;
                end else begin
                    csum_fold = 1'b1;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (idx_q == 6'(HDR_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            hdr_addr_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            dst_q      <= '{default: 8'h00};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hdr_addr_q <= hdr_addr_d;
            len_q      <= len_d;
            err_q      <= err_d;
            dst_q      <= dst_d;
        end
    end

    ip_csum16 u_csum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (csum_clr),
        .add_en   (csum_add),
        .add_word (csum_word),
        .fold_en  (csum_fold),
        .csum     (csum)
    );

    assign hdr_vec = {
        dst_q[DST_MAC_OFF+0], dst_q[DST_MAC_OFF+1], dst_q[DST_MAC_OFF+2],
        dst_q[DST_MAC_OFF+3], dst_q[DST_MAC_OFF+4], dst_q[DST_MAC_OFF+5],
        SRC_MAC, ETHERTYPE_IPV4, IP_VER_IHL_TOS, total_len, ip_id, 16'h0000,
        TTL, IP_PROTO_UDP, csum, SRC_IP,
        dst_q[DST_IP_OFF+0], dst_q[DST_IP_OFF+1], dst_q[DST_IP_OFF+2], dst_q[DST_IP_OFF+3],
        SRC_PORT, dst_q[DST_PORT_OFF], dst_q[DST_PORT_OFF+1], udp_len, 16'h0000
    };

    always_comb begin
        for (int i = 0; i < HDR_LEN; i++) begin
            hdr_bytes[i] = hdr_vec[8*(HDR_LEN-1-i) +: 8];
        end
    end

    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign hdr_addr  = hdr_addr_q;
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? hdr_bytes[idx_q] : 8'h00;
    assign out_last  = out_valid && (idx_q == 6'(HDR_LEN - 1));

endmodule

// File: tb/tb_udp_header_tx.sv
// tb/tb_udp_header_tx.sv - directed vector bench for udp_header_tx
module tb_udp_header_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] payload_len;
    logic        busy;
    logic        err;
    logic [4:0]  hdr_addr;
    logic [7:0]  hdr_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    always #5 clk = ~clk;

    udp_header_tx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .payload_len (payload_len),
        .busy        (busy),
        .err         (err),
        .hdr_addr    (hdr_addr),
        .hdr_data    (hdr_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    logic [7:0] ram [32];
    always @(posedge clk) hdr_data <= ram[hdr_addr];

    typedef struct {
        logic [31:0] dip;
        logic [15:0] dport;
        logic [15:0] plen;
        logic [15:0] exp_tl;
        logic [15:0] exp_cs;
        logic [15:0] exp_ul;
        int          mode;
    } vec_t;

    vec_t        vecs [4];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_id = 16'h0000;
    logic [7:0]  got_b [42];
    logic [7:0]  exp_b [42];
    int          n_got;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] csum_adj(input logic [15:0] cs, input logic [15:0] id);
        logic [16:0] s;
        s = {1'b0, ~cs} + {1'b0, id};
        s = {1'b0, s[15:0]} + {16'b0, s[16]};
        return ~s[15:0];
    endfunction

    task automatic load_ram(input logic [31:0] dip, input logic [15:0] dport);
        for (int i = 0; i < 6; i++) ram[i] = 8'hFF;
        ram[6]  = dip[31:24];
        ram[7]  = dip[23:16];
        ram[8]  = dip[15:8];
        ram[9]  = dip[7:0];
        ram[10] = dport[15:8];
        ram[11] = dport[7:0];
    endtask

    task automatic build_exp(input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] tl,
                             input logic [15:0] id, input logic [15:0] cs, input logic [15:0] ul);
        logic [335:0] v;
        v = {48'hFFFFFFFFFFFF, 48'h00105AD15500, 16'h0800, 16'h4500, tl, id, 16'h0000,
             8'd64, 8'h11, cs, 32'hC0A80102, dip, 16'h80F0, dport, ul, 16'h0000};
        for (int i = 0; i < 42; i++) exp_b[i] = v[8*(41-i) +: 8];
    endtask

    task automatic compare_hdr(input string tag);
        for (int i = 0; i < 42; i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got_b[i]}, {24'h0, exp_b[i]});
        end
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0 repeating; 2: stray start pulse at byte 5
    task automatic run_hdr(input logic [15:0] plen, input int mode, input int abort_at);
        int         cyc;
        int         first_v;
        int         k;
        bit         pulsed;
        logic [7:0] pd;
        logic       pv, pr, pl;
        @(negedge clk);
        start = 1'b1;
        payload_len = plen;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; n_got = 0; first_v = -1; k = 0; pulsed = 0;
        pv = 1'b0; pr = 1'b1; pd = 8'h00; pl = 1'b0;
        while (n_got < 42 && cyc < 400) begin
            if (cyc == 0) check("busy_after_start", {31'b0, busy}, 32'd1);
            if (out_valid && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                check("stall_data", {24'h0, out_data}, {24'h0, pd});
                check("stall_last", {31'b0, out_last}, {31'b0, pl});
            end
            start = 1'b0;
            if (mode == 2 && out_valid && n_got == 5 && !pulsed) begin
                start = 1'b1;
                payload_len = 16'h0010;
                pulsed = 1;
            end
            if (mode == 1 && out_valid) begin
                out_ready = (k % 3 == 0);
                k++;
            end else begin
                out_ready = 1'b1;
            end
            if (abort_at >= 0 && out_valid && n_got == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", {31'b0, out_valid}, 32'd0);
                check("abort_busy", {31'b0, busy}, 32'd0);
                exp_id = 16'h0000;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (out_valid && out_ready) begin
                got_b[n_got] = out_data;
                check("last_flag", {31'b0, out_last}, {31'b0, (n_got == 41)});
                n_got++;
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("handshakes", n_got, 32'd42);
        check("first_byte_latency", first_v, 32'd15);
        check("busy_done", {31'b0, busy}, 32'd0);
        check("valid_done", {31'b0, out_valid}, 32'd0);
`ifdef UDP_HEADER_IP_ID_COUNTER_EN
        if (n_got == 42) exp_id = exp_id + 16'd1;
`endif
    endtask

    initial begin
        logic [15:0] cs;
        bit          quiet;

        vecs[0] = '{32'hFFFFFFFF, 16'h80F0, 16'd0,   16'h001C, 16'hB927, 16'h0008, 0};
        vecs[1] = '{32'h0A000005, 16'h80F0, 16'd100, 16'h0080, 16'hAEBE, 16'h006C, 0};
        vecs[2] = '{32'hFFFFFFFF, 16'h80F0, 16'hFFE3, 16'hFFFF, 16'hB943, 16'hFFEB, 2};
        vecs[3] = '{32'hC0A80164, 16'h1234, 16'h0200, 16'h021C, 16'hF51A, 16'h0208, 1};

        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        load_ram(32'hFFFFFFFF, 16'h80F0);
        rst_n = 1'b0;
        start = 1'b0;
        payload_len = 16'h0000;
        out_ready = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_hdr_addr", {27'b0, hdr_addr}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_last", {31'b0, out_last}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Oversized payload is rejected with a single err pulse and no RAM traffic.
        @(negedge clk);
        start = 1'b1;
        payload_len = 16'hFFE4;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", {31'b0, err}, 32'd1);
        check("err_busy", {31'b0, busy}, 32'd0);
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy || hdr_addr != 5'd0 || err) quiet = 0;
        end
        check("err_quiet_after", {31'b0, quiet}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            load_ram(vecs[v].dip, vecs[v].dport);
            cs = csum_adj(vecs[v].exp_cs, exp_id);
            build_exp(vecs[v].dip, vecs[v].dport, vecs[v].exp_tl, exp_id, cs, vecs[v].exp_ul);
            run_hdr(vecs[v].plen, vecs[v].mode, -1);
            check($sformatf("v%0d_total_len", v), {16'h0, got_b[16], got_b[17]}, {16'h0, vecs[v].exp_tl});
            check($sformatf("v%0d_csum", v), {16'h0, got_b[24], got_b[25]}, {16'h0, cs});
            check($sformatf("v%0d_udp_len", v), {16'h0, got_b[38], got_b[39]}, {16'h0, vecs[v].exp_ul});
            check($sformatf("v%0d_dport", v), {16'h0, got_b[36], got_b[37]}, {16'h0, vecs[v].dport});
            compare_hdr($sformatf("v%0d", v));
        end

        // Reset mid-header, then a fresh header must come out complete from byte 0.
        load_ram(32'hFFFFFFFF, 16'h80F0);
        run_hdr(16'd0, 0, 20);
        build_exp(32'hFFFFFFFF, 16'h80F0, 16'h001C, 16'h0000, 16'hB927, 16'h0008);
        run_hdr(16'd0, 0, -1);
        compare_hdr("post_abort");

        // Three back-to-back headers: ID and checksum track the counter.
        for (int h = 0; h < 3; h++) begin
            logic [15:0] id_now;
            id_now = exp_id;
            cs = csum_adj(16'hB927, id_now);
            run_hdr(16'd0, 0, -1);
            check($sformatf("id_seq%0d", h), {16'h0, got_b[18], got_b[19]}, {16'h0, id_now});
            check($sformatf("id_csum%0d", h), {16'h0, got_b[24], got_b[25]}, {16'h0, cs});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
